// File: rtl/pipe_nand.sv
// Pipelined, valid/ready flow-controlled NAND reduction across WAY groups of WIRE lanes.
// One AND-tree level per register stage; the output inversion sits after the last register.

module gate_and #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);
    assign o_y = i_a & i_b;
endmodule

module gate_not #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_y
);
    assign o_y = ~i_a;
endmodule

module pipe_nand #(
    parameter bit BEHAVIORAL = 1'b1,
    parameter int WAY        = 4,
    parameter int WIRE       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WAY*WIRE-1:0] in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIRE-1:0]     out
);
    localparam int LEVELS = $clog2(WAY);
    localparam int PAD    = 1 << LEVELS;
    localparam int NODES  = PAD - 1;

    // Node numbering: padded inputs are nodes 0..PAD-1, stage s results follow
    // at PAD + (PAD - (PAD >> s)); r_tree holds every registered node in that order.
    logic [PAD*WIRE-1:0]       w_pad;
    logic [(2*PAD-2)*WIRE-1:0] w_src;
    logic [NODES*WIRE-1:0]     w_and;
    logic [NODES*WIRE-1:0]     r_tree;
    logic [LEVELS-1:0]         r_valid;
    logic [LEVELS-1:0]         w_adv;
    logic [WIRE-1:0]           w_last;

    if (PAD > WAY) begin : g_pad
        assign w_pad = {{((PAD - WAY) * WIRE){1'b1}}, in};
    end else begin : g_nopad
        assign w_pad = in;
    end

    if (LEVELS > 1) begin : g_src_deep
        assign w_src = {r_tree[(NODES-1)*WIRE-1:0], w_pad};
    end else begin : g_src_flat
        assign w_src = w_pad;
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
        localparam int N   = PAD >> (s + 1);
        localparam int SRC = 2*PAD - 2*(PAD >> s);
        localparam int DST = PAD - (PAD >> s);
        for (genvar k = 0; k < N; k++) begin : g_node
            if (BEHAVIORAL) begin : g_beh
                assign w_and[(DST+k)*WIRE +: WIRE] =
                    w_src[(SRC+2*k)*WIRE +: WIRE] & w_src[(SRC+2*k+1)*WIRE +: WIRE];
            end else begin : g_gate
                gate_and #(.W(WIRE)) u_and (
                    .i_a (w_src[(SRC+2*k)*WIRE +: WIRE]),
                    .i_b (w_src[(SRC+2*k+1)*WIRE +: WIRE]),
                    .o_y (w_and[(DST+k)*WIRE +: WIRE])
                );
            end
        end
    end

    // Bubble-collapsing advance: a stage may load if it is empty or its successor moves.
    always_comb begin
        logic w_chain;
        w_adv   = '0;
        w_chain = out_ready;
        for (int s = LEVELS - 1; s >= 0; s--) begin
            w_chain  = ~r_valid[s] | w_chain;
            w_adv[s] = w_chain;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tree  <= '0;
            r_valid <= '0;
        end else begin
            if (w_adv[0]) r_valid[0] <= in_valid;
            for (int s = 1; s < LEVELS; s++) begin
                if (w_adv[s]) r_valid[s] <= r_valid[s-1];
            end
            for (int s = 0; s < LEVELS; s++) begin
                for (int k = 0; k < (PAD >> (s + 1)); k++) begin
                    if (w_adv[s])
                        r_tree[(PAD - (PAD >> s) + k)*WIRE +: WIRE] <=
                            w_and[(PAD - (PAD >> s) + k)*WIRE +: WIRE];
                end
            end
        end
    end

    assign w_last    = r_tree[(NODES-1)*WIRE +: WIRE];
    assign out_valid = r_valid[LEVELS-1];
    assign in_ready  = w_adv[0];

    if (BEHAVIORAL) begin : g_out_beh
        assign out = ~w_last;
    end else begin : g_out_gate
        gate_not #(.W(WIRE)) u_not (
            .i_a (w_last),
            .o_y (out)
        );
    end

endmodule

// File: tb/tb_pipe_nand.sv
// Bench for pipe_nand: WAY=4/WIRE=2 main instance plus WAY=3 behavioural and gate builds,
// checked against a queue-based NAND scoreboard and a cycle-indexed expectation table.

module tb_pipe_nand;
    localparam int LEV = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data   = '0;
    logic       in_ready, out_valid;
    logic [1:0] out_data;

    logic       w3_valid     = 1'b0;
    logic [2:0] w3_in        = '0;
    logic       w3_out_ready = 1'b1;
    logic       b3_in_ready, b3_out_valid, b3_out;
    logic       g3_in_ready, g3_out_valid, g3_out;

    pipe_nand #(.BEHAVIORAL(1'b1), .WAY(4), .WIRE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out(out_data)
    );

    pipe_nand #(.BEHAVIORAL(1'b1), .WAY(3), .WIRE(1)) u_b3 (
        .clk(clk), .rst_n(rst_n), .in_valid(w3_valid), .in_ready(b3_in_ready), .in(w3_in),
        .out_valid(b3_out_valid), .out_ready(w3_out_ready), .out(b3_out)
    );

    pipe_nand #(.BEHAVIORAL(1'b0), .WAY(3), .WIRE(1)) u_g3 (
        .clk(clk), .rst_n(rst_n), .in_valid(w3_valid), .in_ready(g3_in_ready), .in(w3_in),
        .out_valid(g3_out_valid), .out_ready(w3_out_ready), .out(g3_out)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] nand4(input logic [7:0] d);
        logic [1:0] acc;
        acc = 2'b11;
        for (int w = 0; w < 4; w++) acc = acc & d[w*2 +: 2];
        return ~acc;
    endfunction

    // Scoreboard for the WAY=4 instance
    logic [1:0] exp_q[$];
    int         acc_q[$];
    bit         mon_en    = 1'b1;
    bit         lat_exact = 1'b0;
    bit         prev_hold = 1'b0;
    logic [1:0] prev_out  = '0;

    always @(negedge clk) begin
        logic [1:0] e;
        int         a;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_hold = 1'b0;
        end else if (mon_en) begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_out);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("order_data", out_data, e);
                    if (lat_exact) chk("latency", cyc - a, LEV);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(nand4(in_data));
                acc_q.push_back(cyc);
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = out_data;
        end
    end

    // Cycle-indexed expectations for the WAY=3 builds (latency 2, out_ready tied high)
    bit   mon3_en = 1'b0;
    bit   e3v[int];
    logic e3o[int];

    always @(negedge clk) begin
        bit   ev;
        logic eo;
        if (mon3_en && rst_n) begin
            ev = e3v.exists(cyc);
            eo = ev ? e3o[cyc] : 1'b0;
            chk("b3_valid", b3_out_valid, ev);
            chk("g3_valid", g3_out_valid, ev);
            if (ev) begin
                chk("b3_out", b3_out, eo);
                chk("g3_out", g3_out, eo);
            end
            chk("b3_ready", b3_in_ready, 1);
            chk("g3_ready", g3_in_ready, 1);
            if (w3_valid) begin
                e3v[cyc + 2] = 1'b1;
                e3o[cyc + 2] = ~&w3_in;
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic v, input logic [2:0] d);
        w3_valid = v;
        w3_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, exp_q.size(), 0);
        chk({tag, "_idle"}, out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a_beat;
        logic [7:0] b_beat;
        int         base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out_data, 2'b11);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Function and latency
        out_ready = 1'b1;
        lat_exact = 1'b1;
        step(1'b1, 8'b11_11_11_01);
        chk("fn_not_yet", out_valid, 0);
        step(1'b1, 8'hFF);
        chk("fn_valid0", out_valid, 1);
        chk("fn_out0", out_data, 2'b10);
        step(1'b0, 8'h00);
        chk("fn_valid1", out_valid, 1);
        chk("fn_out1", out_data, 2'b00);
        drain("fn_drain");

        // Reset with two beats in flight
        lat_exact = 1'b0;
        out_ready = 1'b0;
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        chk("mid_full", in_ready, 0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out", out_data, 2'b11);
        chk("mid_rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00);
            chk("no_stale", out_valid, 0);
            chk("post_rst_ready", in_ready, 1);
        end

        // Streaming, unstalled
        lat_exact = 1'b1;
        base      = n_out;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            chk("stream_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        drain("stream_drain");
        chk("stream_count", n_out - base, 16);

        // Backpressure
        lat_exact = 1'b0;
        out_ready = 1'b0;
        a_beat    = 8'($urandom);
        step(1'b1, a_beat);
        step(1'b1, 8'($urandom));
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head_valid", out_valid, 1);
        chk("bp_head_data", out_data, nand4(a_beat));
        b_beat = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, b_beat);
            chk("bp_stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom));
            chk("bp_recover_valid", out_valid, 1);
        end
        drain("bp_drain");

        // Bubbles collapse under stall
        out_ready = 1'b0;
        a_beat    = 8'($urandom);
        step(1'b1, a_beat);
        chk("bub_ready1", in_ready, 1);
        step(1'b0, 8'h00);
        chk("bub_ready2", in_ready, 1);
        step(1'b1, 8'($urandom));
        chk("bub_ready3", in_ready, 0);
        step(1'b0, 8'h00);
        chk("bub_ready4", in_ready, 0);
        chk("bub_head", out_data, nand4(a_beat));
        drain("bub_drain");

        // WAY=3 padding, both builds
        mon3_en = 1'b1;
        step3(1'b1, 3'b011);
        step3(1'b1, 3'b111);
        step3(1'b0, 3'b000);
        for (int i = 0; i < 20; i++) step3(1'($urandom), 3'($urandom));
        for (int i = 0; i < 4; i++) step3(1'b0, 3'b000);
        mon3_en = 1'b0;

        chk("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
